// File: rtl/regfile_sequencer_if.sv
// ============================================================================
// Module      : regfile_sequencer_if
// Description : Decoder request, register-file port and ALU handshake bundle
//               for the tiny16 register-file sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
) ();

  // decoder request
  logic              req_valid;
  logic              req_ready;
  logic [SEL_W-1:0]  req_src;
  logic [SEL_W-1:0]  req_dst;
  logic              req_wb;

  // register file port
  logic [SEL_W-1:0]  rf_src_sel;
  logic [SEL_W-1:0]  rf_dst_sel;
  logic              rf_out_en;
  logic [DATA_W-1:0] rf_src;
  logic [DATA_W-1:0] rf_dst;
  logic              rf_in_en;
  logic [DATA_W-1:0] rf_in;

  // ALU handshake and status
  logic              op_valid;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              done;
  logic              err;

  modport master (
    input  req_valid, req_src, req_dst, req_wb,
    output req_ready,
    output rf_src_sel, rf_dst_sel, rf_out_en, rf_in_en, rf_in,
    input  rf_src, rf_dst,
    output op_valid, op_a, op_b,
    input  res_valid, res_data,
    output done, err
  );

  modport slave (
    output req_valid, req_src, req_dst, req_wb,
    input  req_ready,
    input  rf_src_sel, rf_dst_sel, rf_out_en, rf_in_en, rf_in,
    output rf_src, rf_dst,
    input  op_valid, op_a, op_b,
    output res_valid, res_data,
    input  done, err
  );

endinterface

`default_nettype wire

// File: rtl/regfile_sequencer.sv
// ============================================================================
// Module      : regfile_sequencer
// Description : Initiator for the tiny16 register-file port: read two operands,
//               hand them to the ALU, write the result back. One op in flight.
//               Optional macro REGSEQ_ZERO_R0_EN makes register 0 read as zero
//               and never be written.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sequencer #(
  parameter int DATA_W  = 16,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  wire logic         clk,
  input  wire logic         rst,
  regfile_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CAPT  = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  // The counter only has to reach TIMEOUT-1; TIMEOUT of 0 disables the check.
  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEL_W-1:0]    r_src;
  logic [SEL_W-1:0]    r_dst;
  logic                r_wb;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [DATA_W-1:0]   r_result;
  logic [c_cnt_w-1:0]  r_cnt;

  logic                w_accept;
  logic                w_timeout;
  logic [DATA_W-1:0]   w_cap_a;
  logic [DATA_W-1:0]   w_cap_b;
  logic                w_wr_en;

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
  assign w_timeout = (TIMEOUT != 0) && (r_state == S_EXEC) &&
                     !bus.res_valid && (r_cnt == c_cnt_last);

`ifdef REGSEQ_ZERO_R0_EN
  assign w_cap_a = (r_src == '0) ? '0 : bus.rf_src;
  assign w_cap_b = (r_dst == '0) ? '0 : bus.rf_dst;
  assign w_wr_en = r_wb && (r_dst != '0);
`else
  assign w_cap_a = bus.rf_src;
  assign w_cap_b = bus.rf_dst;
  assign w_wr_en = r_wb;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.req_ready  = 1'b0;
    bus.rf_out_en  = 1'b0;
    bus.op_valid   = 1'b0;
    bus.rf_in_en   = 1'b0;
    bus.done       = 1'b0;
    bus.err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Held low while reset is asserted so every output reads 0 in reset.
        bus.req_ready = !rst;
        if (w_accept) begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        bus.rf_out_en = 1'b1;
        w_state_nxt   = S_CAPT;
      end
      S_CAPT: begin
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        bus.op_valid = 1'b1;
        if (bus.res_valid) begin
          w_state_nxt = S_WRITE;
        end else if (w_timeout) begin
          bus.err     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        bus.rf_in_en = w_wr_en;
        bus.done     = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_wb     <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_src <= bus.req_src;
        r_dst <= bus.req_dst;
        r_wb  <= bus.req_wb;
      end
      if (r_state == S_CAPT) begin
        r_op_a <= w_cap_a;
        r_op_b <= w_cap_b;
      end
      if ((r_state == S_EXEC) && bus.res_valid) begin
        r_result <= bus.res_data;
      end
    end
  end

  // Counts EXEC cycles spent without a result; idle outside EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == S_EXEC) && !bus.res_valid) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign bus.rf_src_sel = r_src;
  assign bus.rf_dst_sel = r_dst;
  assign bus.rf_in      = r_result;
  assign bus.op_a       = r_op_a;
  assign bus.op_b       = r_op_b;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
// ============================================================================
// Module      : tb_regfile_sequencer
// Description : Directed bench for regfile_sequencer with a behavioural
//               register file; honours REGSEQ_ZERO_R0_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sequencer;

`ifdef REGSEQ_ZERO_R0_EN
  localparam bit c_zero_r0 = 1'b1;
`else
  localparam bit c_zero_r0 = 1'b0;
`endif

  logic clk;
  logic rst;

  regfile_sequencer_if #(.DATA_W(16), .SEL_W(3)) bus ();

  regfile_sequencer #(.DATA_W(16), .SEL_W(3), .TIMEOUT(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file model: read data valid the cycle after rf_out_en
  logic [15:0] r_regs [8] = '{default: 16'h0};
  logic        pl_en  = 1'b0;
  logic [2:0]  pl_idx = 3'd0;
  logic [15:0] pl_val = 16'h0;
  int          oe_cnt = 0;

  always @(posedge clk) begin
    if (bus.rf_out_en) begin
      bus.rf_src <= r_regs[bus.rf_src_sel];
      bus.rf_dst <= r_regs[bus.rf_dst_sel];
      oe_cnt     <= oe_cnt + 1;
    end
    if (pl_en) r_regs[pl_idx] <= pl_val;
    else if (bus.rf_in_en) r_regs[bus.rf_dst_sel] <= bus.rf_in;
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] src, input logic [2:0] dst, input logic wb);
    bus.req_valid = 1'b1;
    bus.req_src   = src;
    bus.req_dst   = dst;
    bus.req_wb    = wb;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pre [8];
    int base;
    pre = '{16'd5, 16'd7, 16'd10, 16'd20, 16'd1, 16'd2, 16'd3, 16'd4};
    bus.req_valid = 1'b0;
    bus.req_src   = '0;
    bus.req_dst   = '0;
    bus.req_wb    = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.rf_src    = '0;
    bus.rf_dst    = '0;
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      pl_en = 1'b1; pl_idx = 3'(i); pl_val = pre[i];
      tick();
    end
    pl_en = 1'b0;
    check("rst ready", bus.req_ready, 0);
    check("rst out_en", bus.rf_out_en, 0);
    check("rst op_a", bus.op_a, 0);
    check("rst done", bus.done, 0);
    rst = 1'b0;
    #1;
    check("rst release ready", bus.req_ready, 1);

    // reset mid-EXEC
    issue(3'd2, 3'd3, 1'b1);
    tick();
    tick();
    check("t1 exec op_valid", bus.op_valid, 1);
    check("t1 exec op_a", bus.op_a, 10);
    rst = 1'b1;
    #1;
    check("t1 rst op_valid", bus.op_valid, 0);
    check("t1 rst op_a", bus.op_a, 0);
    check("t1 rst op_b", bus.op_b, 0);
    check("t1 rst src_sel", bus.rf_src_sel, 0);
    check("t1 rst dst_sel", bus.rf_dst_sel, 0);
    check("t1 rst flags", {bus.req_ready, bus.rf_out_en, bus.rf_in_en, bus.done, bus.err}, 0);
    tick();
    rst = 1'b0;
    #1;
    check("t1 idle ready", bus.req_ready, 1);

    // basic op with write-back
    issue(3'd2, 3'd3, 1'b1);
    check("t2 read out_en", bus.rf_out_en, 1);
    check("t2 read ready", bus.req_ready, 0);
    check("t2 src_sel", bus.rf_src_sel, 2);
    tick();
    check("t2 capt out_en", bus.rf_out_en, 0);
    check("t2 capt op_valid", bus.op_valid, 0);
    tick();
    check("t2 exec op_valid", bus.op_valid, 1);
    check("t2 op_a", bus.op_a, 10);
    check("t2 op_b", bus.op_b, 20);
    tick();
    bus.res_valid = 1'b1; bus.res_data = 16'd30;
    tick();
    bus.res_valid = 1'b0;
    check("t2 wr in_en", bus.rf_in_en, 1);
    check("t2 wr dst_sel", bus.rf_dst_sel, 3);
    check("t2 wr data", bus.rf_in, 30);
    check("t2 wr done", bus.done, 1);
    tick();
    check("t2 post in_en", bus.rf_in_en, 0);
    check("t2 post done", bus.done, 0);
    check("t2 post ready", bus.req_ready, 1);
    check("t2 r3", r_regs[3], 30);

    // src==dst, no write-back
    issue(3'd1, 3'd1, 1'b0);
    tick();
    tick();
    check("t3 op_a", bus.op_a, 7);
    check("t3 op_b", bus.op_b, 7);
    bus.res_valid = 1'b1; bus.res_data = 16'h0099;
    tick();
    bus.res_valid = 1'b0;
    check("t3 wr done", bus.done, 1);
    check("t3 wr in_en", bus.rf_in_en, 0);
    tick();
    check("t3 post done", bus.done, 0);
    check("t3 r1", r_regs[1], 7);

    // ALU timeout after 4 EXEC cycles
    issue(3'd2, 3'd3, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t4 no err early", bus.err, 0);
      tick();
    end
    check("t4 err pulse", bus.err, 1);
    check("t4 err op_valid", bus.op_valid, 1);
    tick();
    check("t4 post err", bus.err, 0);
    check("t4 post done", bus.done, 0);
    check("t4 post in_en", bus.rf_in_en, 0);
    check("t4 post ready", bus.req_ready, 1);
    bus.res_valid = 1'b1; bus.res_data = 16'hdead;
    tick();
    bus.res_valid = 1'b0;
    check("t4 idle res ignored", {bus.done, bus.rf_in_en, bus.req_ready}, 3'b001);

    // result on the timeout cycle completes normally
    issue(3'd2, 3'd3, 1'b1);
    tick();
    tick();
    tick(); tick(); tick();
    bus.res_valid = 1'b1; bus.res_data = 16'h1234;
    #1;
    check("t4b err suppressed", bus.err, 0);
    tick();
    bus.res_valid = 1'b0;
    check("t4b done", bus.done, 1);
    check("t4b wr data", bus.rf_in, 16'h1234);
    tick();
    check("t4b r3", r_regs[3], 16'h1234);

    // back-to-back with req_valid held
    base = oe_cnt;
    bus.req_valid = 1'b1; bus.req_src = 3'd4; bus.req_dst = 3'd5; bus.req_wb = 1'b1;
    tick();
    bus.req_src = 3'd6; bus.req_dst = 3'd7;
    check("t5 read ready", bus.req_ready, 0);
    check("t5 read src_sel", bus.rf_src_sel, 4);
    tick();
    check("t5 capt ready", bus.req_ready, 0);
    tick();
    check("t5 exec ready", bus.req_ready, 0);
    check("t5 op_a", bus.op_a, 1);
    check("t5 op_b", bus.op_b, 2);
    bus.res_valid = 1'b1; bus.res_data = 16'haaaa;
    tick();
    bus.res_valid = 1'b0;
    check("t5 wr ready", bus.req_ready, 0);
    check("t5 wr done", bus.done, 1);
    tick();
    check("t5 idle ready", bus.req_ready, 1);
    check("t5 idle out_en", bus.rf_out_en, 0);
    tick();
    bus.req_valid = 1'b0;
    check("t5 2nd out_en", bus.rf_out_en, 1);
    check("t5 2nd src_sel", bus.rf_src_sel, 6);
    check("t5 2nd dst_sel", bus.rf_dst_sel, 7);
    tick();
    check("t5 out_en count", oe_cnt - base, 2);
    tick();
    check("t5 2nd op_a", bus.op_a, 3);
    bus.res_valid = 1'b1; bus.res_data = 16'h5555;
    tick();
    bus.res_valid = 1'b0;
    check("t5 2nd wr data", bus.rf_in, 16'h5555);
    check("t5 2nd wr sel", bus.rf_dst_sel, 7);
    tick();
    check("t5 r5", r_regs[5], 16'haaaa);
    check("t5 r7", r_regs[7], 16'h5555);

    // register 0 behaviour
    issue(3'd0, 3'd0, 1'b1);
    tick();
    tick();
    check("t6 op_a", bus.op_a, c_zero_r0 ? 32'd0 : 32'd5);
    check("t6 op_b", bus.op_b, c_zero_r0 ? 32'd0 : 32'd5);
    bus.res_valid = 1'b1; bus.res_data = 16'h0077;
    tick();
    bus.res_valid = 1'b0;
    check("t6 wr in_en", bus.rf_in_en, c_zero_r0 ? 32'd0 : 32'd1);
    check("t6 wr done", bus.done, 1);
    tick();
    check("t6 r0", r_regs[0], c_zero_r0 ? 32'd5 : 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
